fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives the icache
//  request (iREN/imemaddr), and feeds IF_ID_pipe_if (instr_i, npc_i, EN, flush).
//  Applies stall from the hazard unit, redirects (branch/jump resolved in EX)
//  and halt committed from MEM/WB. A redirect that arrives mid-miss is deferred
//  until the in-flight response has been drained.
// PARAMETERS
//  PC_INIT   32'h0000_0000  PC value after reset
//  CNT_W     32             width of the fetched-instruction counter
// PORTS
//  CLK          in   1      single clock, rising edge
//  RST          in   1      synchronous, active-high reset
//  ihit         in   1      icache response valid for imemaddr this cycle
//  imemload     in   32     icache instruction data (valid with ihit)
//  stall        in   1      hazard unit: hold PC and IF/ID
//  redirect     in   1      EX: taken branch/jump, flush wrong path
//  redirect_pc  in   32     EX: target for redirect
//  halt         in   1      MEM/WB halt_o: stop fetching permanently
//  iREN         out  1      icache read enable
//  imemaddr     out  32     icache address (= current PC)
//  instr_o      out  32     to IF_ID instr_i
//  npc_o        out  32     to IF_ID npc_i (PC+4 of fetched instr)
//  if_id_EN     out  1      to IF_ID EN: latch instr_o/npc_o
//  if_id_flush  out  1      to IF_ID flush: bubble IF/ID
//  fetch_cnt    out  CNT_W  instructions pushed into IF/ID since reset
// BEHAVIOUR
//  - Reset (RST=1 at posedge): pc<=PC_INIT, state<=FETCH, pend_pc<=0,
//    fetch_cnt<=0. While RST=1: iREN=0, if_id_EN=0, if_id_flush=1.
//  - imemaddr=pc, npc_o=pc+4 (mod 2^32, wraps silently), instr_o=imemload,
//    all combinational. PC increments by 4 only; low 2 bits never altered.
//  - States: FETCH, DRAIN, HALT (fetch_state_t).
//  - FETCH: iREN=1. Priority per cycle: halt > redirect > stall > ihit.
//    halt: state<=HALT, if_id_EN=0, if_id_flush=0.
//    redirect & ihit: pc<=redirect_pc, if_id_flush=1, if_id_EN=0, response
//      discarded, fetch_cnt unchanged.
//    redirect & !ihit: pend_pc<=redirect_pc, state<=DRAIN, if_id_flush=1,
//      pc held (cache request left undisturbed).
//    stall: pc held, if_id_EN=0, if_id_flush=0; ihit ignored (refetched).
//    ihit: pc<=pc+4, if_id_EN=1, fetch_cnt+=1 (wraps at 2^CNT_W).
//    none: pc held, if_id_EN=0, if_id_flush=1 (bubble so IF/ID never repeats).
//  - DRAIN: iREN=1, imemaddr=pc (old), if_id_EN=0, if_id_flush=1 every cycle.
//    ihit: pc<=pend_pc, state<=FETCH (response dropped). A second redirect in
//    DRAIN overwrites pend_pc (latest wins). stall ignored. halt -> HALT.
//  - HALT: iREN=0, if_id_EN=0, if_id_flush=0, pc frozen; redirect/stall/ihit
//    ignored; exit only via RST.
//  - Latency: instruction hit at cycle N appears on IF_ID outputs at N+1.
//  - Reset asserted in any state (incl. DRAIN mid-miss) takes effect at that
//    edge; pending redirect is lost.
// STRUCTURE
//  - cpu_types_pkg: typedef enum logic [1:0] {FETCH, DRAIN, HALT}
//    fetch_state_t; localparam word_t PC_STEP = 32'd4.
//  - Flat module, no sub-module: one always_ff (pc, state, pend_pc,
//    fetch_cnt), one always_comb (next-state and outputs).
// TESTING
//  1 Reset, ihit=1 for 3 cycles -> imemaddr 0,4,8; if_id_EN=1 each cycle;
//    npc_o 4,8,C; fetch_cnt=3.
//  2 pc=0x10, stall=1 2 cycles with ihit=1 -> pc stays 0x10, if_id_EN=0,
//    fetch_cnt unchanged; release -> fetch 0x10.
//  3 pc=0x20, redirect=1 redirect_pc=0x100 with ihit=1 -> if_id_flush=1,
//    next imemaddr=0x100, fetch_cnt unchanged.
//  4 pc=0x20, ihit=0, redirect to 0x200 -> DRAIN, imemaddr stays 0x20 until
//    ihit (3 cycles later), that word dropped, then imemaddr=0x200.
//  5 In DRAIN, second redirect to 0x300 then ihit -> next imemaddr=0x300.
//  6 halt=1 with redirect=1 -> HALT, iREN=0 forever; RST=1 -> pc=PC_INIT,
//    iREN=0/flush=1 during RST, fetch resumes after.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch-stage state encoding and PC stride.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the icache request and feeds IF/ID.
// Redirects that land mid-miss are parked in pendPc until the miss drains.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter int    CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             iREN,
  output logic [31:0]      imemaddr,
  output logic [31:0]      instr_o,
  output logic [31:0]      npc_o,
  output logic             if_id_EN,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] fetch_cnt
);

  word_t            pc, pcNext;
  word_t            pendPc, pendPcNext;
  fetch_state_t     state, stateNext;
  logic [CNT_W-1:0] cntNext;

  assign imemaddr = pc;
  assign npc_o    = pc + PC_STEP;
  assign instr_o  = imemload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc        <= PC_INIT;
      state     <= FETCH;
      pendPc    <= '0;
      fetch_cnt <= '0;
    end else begin
      pc        <= pcNext;
      state     <= stateNext;
      pendPc    <= pendPcNext;
      fetch_cnt <= cntNext;
    end
  end

  always_comb begin
    iREN        = 1'b0;
    if_id_EN    = 1'b0;
    if_id_flush = 1'b0;
    pcNext      = pc;
    stateNext   = state;
    pendPcNext  = pendPc;
    cntNext     = fetch_cnt;
    unique case (state)
      FETCH: begin
        iREN = 1'b1;
        if (halt) begin
          stateNext = HALT;
        end else if (redirect) begin
          if_id_flush = 1'b1;
          if (ihit) begin
            pcNext = redirect_pc;
          end else begin
            // leave the outstanding request alone; retarget once it returns
            pendPcNext = redirect_pc;
            stateNext  = DRAIN;
          end
        end else if (stall) begin
          // hold; a hit here is simply refetched after the stall
        end else if (ihit) begin
          pcNext   = pc + PC_STEP;
          if_id_EN = 1'b1;
          cntNext  = fetch_cnt + CNT_W'(1);
        end else begin
          if_id_flush = 1'b1;
        end
      end
      DRAIN: begin
        iREN        = 1'b1;
        if_id_flush = 1'b1;
        if (halt) begin
          stateNext = HALT;
        end else begin
          if (redirect) pendPcNext = redirect_pc;
          if (ihit) begin
            pcNext    = redirect ? redirect_pc : pendPc;
            stateNext = FETCH;
          end
        end
      end
      HALT: begin
      end
      default: stateNext = FETCH;
    endcase
    if (RST) begin
      iREN        = 1'b0;
      if_id_EN    = 1'b0;
      if_id_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;
  logic        CLK = 1'b0;
  logic        RST, ihit, stall, redirect, halt;
  logic [31:0] imemload, redirect_pc;
  logic        iREN, if_id_EN, if_id_flush;
  logic [31:0] imemaddr, instr_o, npc_o, fetch_cnt;

  int total = 0;
  int bad   = 0;

  // model state: architectural PC, count, whether a redirect waits on a miss, halted
  logic [31:0] mPc, mPendPc, mCnt;
  bit          mPend, mHalted;

  fetch_stage #(.PC_INIT(32'h0), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .iREN(iREN), .imemaddr(imemaddr), .instr_o(instr_o), .npc_o(npc_o),
    .if_id_EN(if_id_EN), .if_id_flush(if_id_flush), .fetch_cnt(fetch_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare combinational outputs, then advance the model.
  task automatic step(input bit r, input bit h, input bit s, input bit rd,
                      input logic [31:0] rpc, input bit hl);
    bit eIren, eEn, eFl;
    @(negedge CLK);
    RST = r; ihit = h; stall = s; redirect = rd; redirect_pc = rpc; halt = hl;
    imemload = $urandom;
    #1;
    if (r)            begin eIren = 0; eEn = 0; eFl = 1; end
    else if (mHalted) begin eIren = 0; eEn = 0; eFl = 0; end
    else if (mPend)   begin eIren = 1; eEn = 0; eFl = 1; end
    else begin
      eIren = 1;
      if (hl)      begin eEn = 0; eFl = 0; end
      else if (rd) begin eEn = 0; eFl = 1; end
      else if (s)  begin eEn = 0; eFl = 0; end
      else if (h)  begin eEn = 1; eFl = 0; end
      else         begin eEn = 0; eFl = 1; end
    end
    chk("iREN", {31'b0, iREN}, {31'b0, eIren});
    chk("en", {31'b0, if_id_EN}, {31'b0, eEn});
    chk("flush", {31'b0, if_id_flush}, {31'b0, eFl});
    chk("addr", imemaddr, mPc);
    chk("npc", npc_o, mPc + 32'd4);
    chk("instr", instr_o, imemload);
    chk("cnt", fetch_cnt, mCnt);
    if (r) begin
      mPc = 0; mCnt = 0; mPend = 0; mPendPc = 0; mHalted = 0;
    end else if (mHalted) begin
    end else if (hl) begin
      mHalted = 1;
    end else if (mPend) begin
      if (rd) mPendPc = rpc;
      if (h) begin mPc = mPendPc; mPend = 0; end
    end else if (rd) begin
      if (h) mPc = rpc;
      else begin mPend = 1; mPendPc = rpc; end
    end else if (!s && h) begin
      mPc = mPc + 32'd4; mCnt = mCnt + 1;
    end
  endtask

  task automatic postEdge(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk(tag, got, exp);
  endtask

  initial begin
    RST = 1; ihit = 0; stall = 0; redirect = 0; redirect_pc = 0; halt = 0; imemload = 0;
    mPc = 0; mCnt = 0; mPend = 0; mPendPc = 0; mHalted = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // sequential fetch
    repeat (3) step(0, 1, 0, 0, 0, 0);
    @(posedge CLK); #1;
    postEdge("t1cnt", fetch_cnt, 32'd3);
    postEdge("t1addr", imemaddr, 32'hC);
    step(0, 1, 0, 0, 0, 0);
    // stall with hits
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    @(posedge CLK); #1;
    postEdge("t2pc", imemaddr, 32'h10);
    postEdge("t2cnt", fetch_cnt, 32'd4);
    repeat (4) step(0, 1, 0, 0, 0, 0);
    // redirect on hit
    step(0, 1, 0, 1, 32'h100, 0);
    @(posedge CLK); #1;
    postEdge("t3pc", imemaddr, 32'h100);
    postEdge("t3cnt", fetch_cnt, 32'd8);
    // redirect mid-miss
    step(0, 1, 0, 1, 32'h20, 0);
    step(0, 0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    @(posedge CLK); #1;
    postEdge("t4hold", imemaddr, 32'h20);
    step(0, 1, 0, 0, 0, 0);
    @(posedge CLK); #1;
    postEdge("t4pc", imemaddr, 32'h200);
    // second redirect during drain
    step(0, 0, 0, 1, 32'h50, 0);
    step(0, 0, 0, 1, 32'h300, 0);
    step(0, 1, 0, 0, 0, 0);
    @(posedge CLK); #1;
    postEdge("t5pc", imemaddr, 32'h300);
    // halt beats redirect, then reset
    step(0, 1, 0, 1, 32'h400, 1);
    repeat (5) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 32'h500, 0);
    @(posedge CLK); #1;
    postEdge("t6iren", {31'b0, iREN}, 32'd0);
    postEdge("t6pc", imemaddr, 32'h300);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    @(posedge CLK); #1;
    postEdge("t6rst", imemaddr, 32'h4);
    // reset while draining
    step(0, 0, 0, 1, 32'h600, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    @(posedge CLK); #1;
    postEdge("t7pc", imemaddr, 32'h4);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, hl;
      r  = mHalted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
      hl = ($urandom_range(0, 149) == 0);
      step(r, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC, hl);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
